// File: rtl/bch_decode_ctrl.sv
// bch_decode_ctrl: sequential BCH(63,51) t=2 decoder over GF(2^6), x^6+x+1.
// Bit-serial S1/S3 syndromes, single-step key equation, 63-cycle Chien search.
// Optional macro BCH_CTRL_FASTPATH_EN: zero-syndrome words skip the Chien search.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_data  received word (bit i = coefficient of x^i)
//   out_valid/out_ready        result handshake
//   out_data                   corrected word (original word when out_fail)
//   out_err_cnt, out_fail      bits corrected (0..2), uncorrectable flag
//   cnt_clear                  synchronous clear of the statistics counters
//   cnt_corr, cnt_fail         saturating corrected / failed word counters
module bch_decode_ctrl #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [62:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [62:0]       out_data,
  output logic [1:0]        out_err_cnt,
  output logic              out_fail,
  input  logic              cnt_clear,
  output logic [STAT_W-1:0] cnt_corr,
  output logic [STAT_W-1:0] cnt_fail
);

  localparam logic [5:0] ALPHA_INV = 6'b100001;
  localparam logic [5:0] LAST_IDX  = 6'd62;

  typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, DONE} state_e;

  // Multiply by alpha
  function automatic logic [5:0] gf_mul_a(input logic [5:0] s);
    return {s[4:0], 1'b0} ^ {4'b0000, s[5], s[5]};
  endfunction

  // General GF(2^6) multiply: carry-less product then reduce by x^6+x+1
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int k = 0; k < 6; k++)
      if (b[k]) p = p ^ (11'(a) << k);
    for (int k = 10; k >= 6; k--)
      if (p[k]) p = p ^ (11'(7'b1000011) << (k - 6));
    return p[5:0];
  endfunction

  // Multiplicative inverse table; entry 0 is a don't-care
  function automatic logic [5:0] gf_inv(input logic [5:0] v);
    logic [5:0] r;
    case (v)
      6'h01: r = 6'h01; 6'h02: r = 6'h21; 6'h03: r = 6'h3E; 6'h04: r = 6'h31;
      6'h05: r = 6'h2B; 6'h06: r = 6'h1F; 6'h07: r = 6'h2C; 6'h08: r = 6'h39;
      6'h09: r = 6'h25; 6'h0A: r = 6'h34; 6'h0B: r = 6'h1C; 6'h0C: r = 6'h2E;
      6'h0D: r = 6'h28; 6'h0E: r = 6'h16; 6'h0F: r = 6'h19; 6'h10: r = 6'h3D;
      6'h11: r = 6'h36; 6'h12: r = 6'h33; 6'h13: r = 6'h27; 6'h14: r = 6'h1A;
      6'h15: r = 6'h23; 6'h16: r = 6'h0E; 6'h17: r = 6'h18; 6'h18: r = 6'h17;
      6'h19: r = 6'h0F; 6'h1A: r = 6'h14; 6'h1B: r = 6'h22; 6'h1C: r = 6'h0B;
      6'h1D: r = 6'h35; 6'h1E: r = 6'h2D; 6'h1F: r = 6'h06; 6'h20: r = 6'h3F;
      6'h21: r = 6'h02; 6'h22: r = 6'h1B; 6'h23: r = 6'h15; 6'h24: r = 6'h38;
      6'h25: r = 6'h09; 6'h26: r = 6'h32; 6'h27: r = 6'h13; 6'h28: r = 6'h0D;
      6'h29: r = 6'h2F; 6'h2A: r = 6'h30; 6'h2B: r = 6'h05; 6'h2C: r = 6'h07;
      6'h2D: r = 6'h1E; 6'h2E: r = 6'h0C; 6'h2F: r = 6'h29; 6'h30: r = 6'h2A;
      6'h31: r = 6'h04; 6'h32: r = 6'h26; 6'h33: r = 6'h12; 6'h34: r = 6'h0A;
      6'h35: r = 6'h1D; 6'h36: r = 6'h11; 6'h37: r = 6'h3C; 6'h38: r = 6'h24;
      6'h39: r = 6'h08; 6'h3A: r = 6'h3B; 6'h3B: r = 6'h3A; 6'h3C: r = 6'h37;
      6'h3D: r = 6'h10; 6'h3E: r = 6'h03; 6'h3F: r = 6'h20;
      default: r = 6'h00;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [62:0]         word_q, word_d;       // received word, kept for fail restore
  logic [62:0]         corr_q, corr_d;       // working corrected word
  logic [5:0]          s1_q, s1_d, s3_q, s3_d;
  logic [5:0]          sig1_q, sig1_d, sig2_q, sig2_d;
  logic [5:0]          x_q, x_d;
  logic [5:0]          idx_q, idx_d;
  logic [1:0]          roots_q, roots_d, exp_roots_q, exp_roots_d;
  logic                fail_q, fail_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [62:0]         out_data_q, out_data_d;
  logic [1:0]          out_err_cnt_q, out_err_cnt_d;
  logic                out_fail_q, out_fail_d;
  logic [STAT_W-1:0]   cnt_corr_q, cnt_corr_d, cnt_fail_q, cnt_fail_d;

  logic [5:0]          s1_sq, s1_cube, chien_sum;
  logic                hit, end_fail, handshake;
  logic [1:0]          roots_inc;
  logic [62:0]         corr_flip;

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    corr_d        = corr_q;
    s1_d          = s1_q;
    s3_d          = s3_q;
    sig1_d        = sig1_q;
    sig2_d        = sig2_q;
    x_d           = x_q;
    idx_d         = idx_q;
    roots_d       = roots_q;
    exp_roots_d   = exp_roots_q;
    fail_d        = fail_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_err_cnt_d = out_err_cnt_q;
    out_fail_d    = out_fail_q;
    cnt_corr_d    = cnt_corr_q;
    cnt_fail_d    = cnt_fail_q;

    s1_sq     = gf_mul(s1_q, s1_q);
    s1_cube   = gf_mul(s1_sq, s1_q);
    chien_sum = gf_mul(sig1_q, x_q) ^ gf_mul(sig2_q, gf_mul(x_q, x_q));
    // A fail found in KEY suppresses every flip
    hit       = !fail_q && (chien_sum == 6'd1);
    corr_flip = corr_q ^ (63'(hit) << idx_q);
    roots_inc = roots_q + 2'(hit);
    end_fail  = fail_q || (roots_inc != exp_roots_q);
    handshake = out_valid_q && out_ready;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          word_d     = in_data;
          corr_d     = in_data;
          s1_d       = '0;
          s3_d       = '0;
          idx_d      = LAST_IDX;
          in_ready_d = 1'b0;
          state_d    = SYND;
        end
      end
      // Horner evaluation of r(a) and r(a^3), highest coefficient first
      SYND: begin
        s1_d  = gf_mul_a(s1_q) ^ {5'b0, word_q[idx_q]};
        s3_d  = gf_mul_a(gf_mul_a(gf_mul_a(s3_q))) ^ {5'b0, word_q[idx_q]};
        idx_d = idx_q - 6'd1;
        if (idx_q == 6'd0) state_d = KEY;
      end
      KEY: begin
        x_d         = 6'd1;
        idx_d       = 6'd0;
        roots_d     = 2'd0;
        sig1_d      = s1_q;
        sig2_d      = '0;
        fail_d      = 1'b0;
        exp_roots_d = 2'd0;
        state_d     = CHIEN;
        if (s1_q == 6'd0) begin
          if (s3_q != 6'd0) begin
            fail_d = 1'b1;
          end else begin
`ifdef BCH_CTRL_FASTPATH_EN
            state_d       = DONE;
            out_valid_d   = 1'b1;
            out_data_d    = word_q;
            out_err_cnt_d = 2'd0;
            out_fail_d    = 1'b0;
`endif
          end
        end else if (s3_q == s1_cube) begin
          exp_roots_d = 2'd1;
        end else begin
          sig2_d      = s1_sq ^ gf_mul(s3_q, gf_inv(s1_q));
          exp_roots_d = 2'd2;
        end
      end
      // Step i tests x = a^-i, i.e. whether bit i is an error location
      CHIEN: begin
        corr_d  = corr_flip;
        roots_d = roots_inc;
        x_d     = gf_mul(x_q, ALPHA_INV);
        idx_d   = idx_q + 6'd1;
        if (idx_q == LAST_IDX) begin
          state_d       = DONE;
          out_valid_d   = 1'b1;
          out_fail_d    = end_fail;
          out_data_d    = end_fail ? word_q : corr_flip;
          out_err_cnt_d = end_fail ? 2'd0 : roots_inc;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Statistics: clear has priority over the handshake increment
    if (cnt_clear) begin
      cnt_corr_d = '0;
      cnt_fail_d = '0;
    end else if (handshake) begin
      if (out_fail_q && (cnt_fail_q != '1))
        cnt_fail_d = cnt_fail_q + STAT_W'(1);
      if (!out_fail_q && (out_err_cnt_q != 2'd0) && (cnt_corr_q != '1))
        cnt_corr_d = cnt_corr_q + STAT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      word_q        <= '0;
      corr_q        <= '0;
      s1_q          <= '0;
      s3_q          <= '0;
      sig1_q        <= '0;
      sig2_q        <= '0;
      x_q           <= '0;
      idx_q         <= '0;
      roots_q       <= '0;
      exp_roots_q   <= '0;
      fail_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_err_cnt_q <= '0;
      out_fail_q    <= 1'b0;
      cnt_corr_q    <= '0;
      cnt_fail_q    <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      corr_q        <= corr_d;
      s1_q          <= s1_d;
      s3_q          <= s3_d;
      sig1_q        <= sig1_d;
      sig2_q        <= sig2_d;
      x_q           <= x_d;
      idx_q         <= idx_d;
      roots_q       <= roots_d;
      exp_roots_q   <= exp_roots_d;
      fail_q        <= fail_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_err_cnt_q <= out_err_cnt_d;
      out_fail_q    <= out_fail_d;
      cnt_corr_q    <= cnt_corr_d;
      cnt_fail_q    <= cnt_fail_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_err_cnt = out_err_cnt_q;
  assign out_fail    = out_fail_q;
  assign cnt_corr    = cnt_corr_q;
  assign cnt_fail    = cnt_fail_q;

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Directed testbench for bch_decode_ctrl: a 16-bit-counter instance and a
// 2-bit-counter instance share the stimulus; the second shows saturation.
module tb_bch_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [62:0] in_data;
  logic        out_ready;
  logic        cnt_clear;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [62:0] out_data,  out_data2;
  logic [1:0]  out_err_cnt, out_err_cnt2;
  logic        out_fail,  out_fail2;
  logic [15:0] cnt_corr,  cnt_fail;
  logic [1:0]  cnt_corr2, cnt_fail2;

  localparam logic [62:0] G  = 63'h1539;        // generator polynomial, a codeword
  localparam logic [62:0] GH = 63'h1539 << 50;  // cyclic shift of G, occupies bit 62
`ifdef BCH_CTRL_FASTPATH_EN
  localparam int LAT_CLEAN = 65;
`else
  localparam int LAT_CLEAN = 128;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_corr = 0, exp_fail = 0, exp_corr2 = 0, exp_fail2 = 0;

  always #5 clk = ~clk;

  bch_decode_ctrl #(.STAT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_cnt(out_err_cnt), .out_fail(out_fail),
    .cnt_clear(cnt_clear), .cnt_corr(cnt_corr), .cnt_fail(cnt_fail)
  );

  bch_decode_ctrl #(.STAT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_err_cnt(out_err_cnt2), .out_fail(out_fail2),
    .cnt_clear(cnt_clear), .cnt_corr(cnt_corr2), .cnt_fail(cnt_fail2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),    64'd1);
    check({tag, "_out_valid"}, 64'(out_valid),   64'd0);
    check({tag, "_out_data"},  64'(out_data),    64'd0);
    check({tag, "_err_cnt"},   64'(out_err_cnt), 64'd0);
    check({tag, "_fail"},      64'(out_fail),    64'd0);
    check({tag, "_cnt_corr"},  64'(cnt_corr),    64'd0);
    check({tag, "_cnt_fail"},  64'(cnt_fail),    64'd0);
    check({tag, "_cnt_corr2"}, 64'(cnt_corr2),   64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic decode(input string tag, input logic [62:0] din, input logic [62:0] exp_d,
                        input logic [1:0] exp_e, input logic exp_f, input int exp_lat,
                        input int hold, input bit glitch, input bit clr);
    int          n;
    int          c;
    bit          stable;
    bit          glitch_ok;
    logic [62:0] held;
    out_ready = (hold == 0);
    in_data   = din;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 64'(n < 400), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = '0;
    c         = 0;
    glitch_ok = 1'b1;
    while (!out_valid && c < 400) begin
      if (glitch) begin
        if (c >= 3 && c < 6) begin
          in_valid = 1'b1;
          in_data  = 63'h5;
          if (in_ready) glitch_ok = 1'b0;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    if (glitch) check({tag, "_no_accept"}, 64'(glitch_ok), 64'd1);
    check({tag, "_latency"},   64'(c + 1),       64'(exp_lat));
    check({tag, "_data"},      64'(out_data),    64'(exp_d));
    check({tag, "_err_cnt"},   64'(out_err_cnt), 64'(exp_e));
    check({tag, "_fail"},      64'(out_fail),    64'(exp_f));
    check({tag, "_busy"},      64'(in_ready),    64'd0);
    if (hold > 0) begin
      held   = out_data;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!out_valid || in_ready || (out_data !== held)) stable = 1'b0;
      end
      check({tag, "_hold_stable"}, 64'(stable), 64'd1);
      out_ready = 1'b1;
    end
    cnt_clear = clr;
    @(negedge clk);
    cnt_clear = 1'b0;
    out_ready = 1'b0;
    if (clr) begin
      exp_corr = 0; exp_fail = 0; exp_corr2 = 0; exp_fail2 = 0;
    end else if (exp_f) begin
      exp_fail++;
      if (exp_fail2 < 3) exp_fail2++;
    end else if (exp_e != 2'd0) begin
      exp_corr++;
      if (exp_corr2 < 3) exp_corr2++;
    end
    check({tag, "_ready_after"}, 64'(in_ready),  64'd1);
    check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    check({tag, "_cnt_corr"},    64'(cnt_corr),  64'(exp_corr));
    check({tag, "_cnt_fail"},    64'(cnt_fail),  64'(exp_fail));
    check({tag, "_cnt_corr2"},   64'(cnt_corr2), 64'(exp_corr2));
    check({tag, "_cnt_fail2"},   64'(cnt_fail2), 64'(exp_fail2));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    decode("clean",     G,                                G,      2'd0, 1'b0, LAT_CLEAN, 0, 1'b0, 1'b0);
    decode("single20",  G ^ (63'd1 << 20),                G,      2'd1, 1'b0, 128, 0, 1'b0, 1'b0);
    decode("dbl_edge",  (63'd1 << 62) | 63'd1,            63'd0,  2'd2, 1'b0, 128, 0, 1'b0, 1'b0);
    decode("triple",    63'h7,                            63'h7,  2'd0, 1'b1, 128, 0, 1'b0, 1'b0);
    decode("single_b0", GH ^ 63'd1,                       GH,     2'd1, 1'b0, 128, 0, 1'b0, 1'b0);
    decode("dbl_mid",   G ^ (63'd1 << 5) ^ (63'd1 << 40), G,      2'd2, 1'b0, 128, 0, 1'b0, 1'b0);
    decode("backpress", G ^ (63'd1 << 33),                G,      2'd1, 1'b0, 128, 10, 1'b1, 1'b0);
    decode("clr_hs",    G ^ (63'd1 << 7),                 G,      2'd1, 1'b0, 128, 0, 1'b0, 1'b1);

    // Reset in the middle of the Chien search
    in_data  = G ^ (63'd1 << 9);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (69) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_corr = 0; exp_fail = 0; exp_corr2 = 0; exp_fail2 = 0;
    @(negedge clk);

    decode("post_rst",  G ^ (63'd1 << 3) ^ (63'd1 << 61), G, 2'd2, 1'b0, 128, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      decode("sat", G ^ (63'd1 << (k * 11 + 2)), G, 2'd1, 1'b0, 128, 0, 1'b0, 1'b0);
    check("final_cnt_corr",  64'(cnt_corr),  64'd6);
    check("final_cnt_corr2", 64'(cnt_corr2), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
